// File: rtl/col_perm_seq.sv
// Column permutation step: finds the min-norm (or max-norm with COLPERM_MAXSEL_EN)
// column among columns k..NCOL-1, then swaps it into position k.
module col_perm_seq #(
    parameter int NCOL    = 8,
    parameter int NROW    = 8,
    parameter int WL      = 16,
    parameter int NORM_WL = 24,
    localparam int IDX_W  = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IDX_W-1:0]             k_i,
    input  logic [NCOL*NROW*WL-1:0]      Hmatrix_i,
    input  logic [NCOL*NORM_WL-1:0]      colnorm_i,
    input  logic [NCOL*IDX_W-1:0]        colorder_i,
`ifdef COLPERM_MAXSEL_EN
    input  logic                         sel_max_i,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NCOL*NROW*WL-1:0]      Hmatrix_o,
    output logic [NCOL*NORM_WL-1:0]      colnorm_o,
    output logic [NCOL*IDX_W-1:0]        colorder_o,
    output logic [IDX_W-1:0]             mincol_o
);

    localparam int CW = NROW * WL;

    typedef enum logic [1:0] {IDLE, SCAN, SWAP, DONE} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      h_q     [NCOL];
    logic [NORM_WL-1:0] norm_q  [NCOL];
    logic [IDX_W-1:0]   order_q [NCOL];

    logic [IDX_W-1:0] k_q, p_q, best_q, mincol_q;
    logic [IDX_W-1:0] k_clamped;
    logic             p_last;
    logic             better;

`ifdef COLPERM_MAXSEL_EN
    logic sel_max_q;
`endif

    // Out-of-range stage indices (only reachable for non-power-of-2 NCOL) map to the last column.
    assign k_clamped = (32'(k_i) >= NCOL) ? IDX_W'(NCOL - 1) : k_i;
    assign p_last    = (p_q == IDX_W'(NCOL - 1));

`ifdef COLPERM_MAXSEL_EN
    assign better = sel_max_q ? (norm_q[p_q] > norm_q[best_q])
                              : (norm_q[p_q] < norm_q[best_q]);
`else
    assign better = (norm_q[p_q] < norm_q[best_q]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (p_last) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the column storage doubles as the output registers, so it must be reset
    // to give all-zero outputs; non-blocking assignments let the swap read old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCOL; c++) begin
                h_q[c]     <= '0;
                norm_q[c]  <= '0;
                order_q[c] <= '0;
            end
            k_q       <= '0;
            p_q       <= '0;
            best_q    <= '0;
            mincol_q  <= '0;
`ifdef COLPERM_MAXSEL_EN
            sel_max_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < NCOL; c++) begin
                            h_q[c]     <= Hmatrix_i[c*CW +: CW];
                            norm_q[c]  <= colnorm_i[c*NORM_WL +: NORM_WL];
                            order_q[c] <= colorder_i[c*IDX_W +: IDX_W];
                        end
                        k_q    <= k_clamped;
                        p_q    <= k_clamped;
                        best_q <= k_clamped;
`ifdef COLPERM_MAXSEL_EN
                        sel_max_q <= sel_max_i;
`endif
                    end
                end
                SCAN: begin
                    // Strict comparison keeps the earliest column on ties.
                    if (p_q == k_q || better) begin
                        best_q <= p_q;
                    end
                    p_q <= p_q + 1'b1;
                end
                SWAP: begin
                    h_q[k_q]        <= h_q[best_q];
                    h_q[best_q]     <= h_q[k_q];
                    norm_q[k_q]     <= norm_q[best_q];
                    norm_q[best_q]  <= norm_q[k_q];
                    order_q[k_q]    <= order_q[best_q];
                    order_q[best_q] <= order_q[k_q];
                    mincol_q        <= best_q;
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar c = 0; c < NCOL; c++) begin : g_pack
        assign Hmatrix_o[c*CW +: CW]            = h_q[c];
        assign colnorm_o[c*NORM_WL +: NORM_WL]  = norm_q[c];
        assign colorder_o[c*IDX_W +: IDX_W]     = order_q[c];
    end

    assign mincol_o = mincol_q;

endmodule
